// File: rtl/axi_rd_arb2.sv
// Two-to-one AXI3 read arbiter: round-robin AR grant into a registered shared port,
// combinational R routing by RID[IDW], per-master outstanding-burst throttling.
module axi_rd_arb2 #(
  parameter int AW      = 32,
  parameter int IDW     = 4,
  parameter int LW      = 4,
  parameter int DW      = 128,
  parameter int MAX_OUT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m0ARVALID,
  output logic           m0ARREADY,
  input  logic [AW-1:0]  m0ARADDR,
  input  logic [LW-1:0]  m0ARLEN,
  input  logic [IDW-1:0] m0ARID,
  output logic           m0RVALID,
  input  logic           m0RREADY,
  output logic [DW-1:0]  m0RDATA,
  output logic           m0RLAST,
  output logic [IDW-1:0] m0RID,
  input  logic           m1ARVALID,
  output logic           m1ARREADY,
  input  logic [AW-1:0]  m1ARADDR,
  input  logic [LW-1:0]  m1ARLEN,
  input  logic [IDW-1:0] m1ARID,
  output logic           m1RVALID,
  input  logic           m1RREADY,
  output logic [DW-1:0]  m1RDATA,
  output logic           m1RLAST,
  output logic [IDW-1:0] m1RID,
  output logic           sARVALID,
  input  logic           sARREADY,
  output logic [AW-1:0]  sARADDR,
  output logic [LW-1:0]  sARLEN,
  output logic [IDW:0]   sARID,
  input  logic           sRVALID,
  output logic           sRREADY,
  input  logic [DW-1:0]  sRDATA,
  input  logic           sRLAST,
  input  logic [IDW:0]   sRID,
  output logic           idle,
  output logic           err
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic           sarvalid_q, sarvalid_d;
  logic [AW-1:0]  saraddr_q, saraddr_d;
  logic [LW-1:0]  sarlen_q, sarlen_d;
  logic [IDW:0]   sarid_q, sarid_d;
  logic [CW-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic           ptr_q, ptr_d;   // last granted master
  logic           err_q, err_d;

  logic ld, elig0, elig1, gnt0, gnt1;
  logic sel, rlast_hs, dec0, dec1, dec0_ok, dec1_ok;

  always_comb begin
    ld    = !sarvalid_q || sARREADY;
    elig0 = m0ARVALID && (cnt0_q < MAX_CNT);
    elig1 = m1ARVALID && (cnt1_q < MAX_CNT);
    gnt0  = !rst && ld && elig0 && (!elig1 || ptr_q);
    gnt1  = !rst && ld && elig1 && (!elig0 || !ptr_q);

    sel      = sRID[IDW];
    rlast_hs = sRVALID && sRREADY && sRLAST;
    dec0     = rlast_hs && !sel;
    dec1     = rlast_hs && sel;
    dec0_ok  = dec0 && (cnt0_q != '0);
    dec1_ok  = dec1 && (cnt1_q != '0);
  end

  always_comb begin
    sarvalid_d = sarvalid_q;
    saraddr_d  = saraddr_q;
    sarlen_d   = sarlen_q;
    sarid_d    = sarid_q;
    ptr_d      = ptr_q;
    if (ld) begin
      sarvalid_d = gnt0 || gnt1;
      if (gnt0) begin
        saraddr_d = m0ARADDR;
        sarlen_d  = m0ARLEN;
        sarid_d   = {1'b0, m0ARID};
        ptr_d     = 1'b0;
      end else if (gnt1) begin
        saraddr_d = m1ARADDR;
        sarlen_d  = m1ARLEN;
        sarid_d   = {1'b1, m1ARID};
        ptr_d     = 1'b1;
      end
    end

    cnt0_d = cnt0_q;
    if (gnt0 && !dec0_ok)      cnt0_d = cnt0_q + CW'(1);
    else if (!gnt0 && dec0_ok) cnt0_d = cnt0_q - CW'(1);
    cnt1_d = cnt1_q;
    if (gnt1 && !dec1_ok)      cnt1_d = cnt1_q + CW'(1);
    else if (!gnt1 && dec1_ok) cnt1_d = cnt1_q - CW'(1);

    // A last beat for a master with nothing outstanding is a fabric protocol error.
    err_d = err_q || (dec0 && !dec0_ok) || (dec1 && !dec1_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sarvalid_q <= 1'b0;
      saraddr_q  <= '0;
      sarlen_q   <= '0;
      sarid_q    <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      ptr_q      <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      sarvalid_q <= sarvalid_d;
      saraddr_q  <= saraddr_d;
      sarlen_q   <= sarlen_d;
      sarid_q    <= sarid_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
    end
  end

  assign m0ARREADY = gnt0;
  assign m1ARREADY = gnt1;
  assign sARVALID  = sarvalid_q;
  assign sARADDR   = saraddr_q;
  assign sARLEN    = sarlen_q;
  assign sARID     = sarid_q;

  assign m0RVALID = sRVALID && !sel;
  assign m1RVALID = sRVALID && sel;
  assign sRREADY  = sel ? m1RREADY : m0RREADY;
  assign m0RDATA  = sRDATA;
  assign m1RDATA  = sRDATA;
  assign m0RLAST  = sRLAST;
  assign m1RLAST  = sRLAST;
  assign m0RID    = sRID[IDW-1:0];
  assign m1RID    = sRID[IDW-1:0];

  assign idle = (cnt0_q == '0) && (cnt1_q == '0) && !sarvalid_q;
  assign err  = err_q;

endmodule

// File: tb/tb_axi_rd_arb2.sv
// Bench for axi_rd_arb2 (MAX_OUT=2): AR scoreboard, R-routing vector table, hand-written corner sequences.
module tb_axi_rd_arb2;
  localparam int AW = 32, IDW = 4, LW = 4, DW = 128, MAX_OUT = 2;

  logic clk = 1'b0, rst;
  logic m0ARVALID, m0ARREADY, m0RVALID, m0RREADY, m0RLAST;
  logic [AW-1:0] m0ARADDR; logic [LW-1:0] m0ARLEN; logic [IDW-1:0] m0ARID, m0RID; logic [DW-1:0] m0RDATA;
  logic m1ARVALID, m1ARREADY, m1RVALID, m1RREADY, m1RLAST;
  logic [AW-1:0] m1ARADDR; logic [LW-1:0] m1ARLEN; logic [IDW-1:0] m1ARID, m1RID; logic [DW-1:0] m1RDATA;
  logic sARVALID, sARREADY, sRVALID, sRREADY, sRLAST, idle, err;
  logic [AW-1:0] sARADDR; logic [LW-1:0] sARLEN; logic [IDW:0] sARID, sRID; logic [DW-1:0] sRDATA;

  axi_rd_arb2 #(.AW(AW), .IDW(IDW), .LW(LW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .m0ARVALID(m0ARVALID), .m0ARREADY(m0ARREADY), .m0ARADDR(m0ARADDR), .m0ARLEN(m0ARLEN), .m0ARID(m0ARID),
    .m0RVALID(m0RVALID), .m0RREADY(m0RREADY), .m0RDATA(m0RDATA), .m0RLAST(m0RLAST), .m0RID(m0RID),
    .m1ARVALID(m1ARVALID), .m1ARREADY(m1ARREADY), .m1ARADDR(m1ARADDR), .m1ARLEN(m1ARLEN), .m1ARID(m1ARID),
    .m1RVALID(m1RVALID), .m1RREADY(m1RREADY), .m1RDATA(m1RDATA), .m1RLAST(m1RLAST), .m1RID(m1RID),
    .sARVALID(sARVALID), .sARREADY(sARREADY), .sARADDR(sARADDR), .sARLEN(sARLEN), .sARID(sARID),
    .sRVALID(sRVALID), .sRREADY(sRREADY), .sRDATA(sRDATA), .sRLAST(sRLAST), .sRID(sRID),
    .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [IDW:0]  id;
  } ar_t;
  ar_t sb_q[$];

  typedef struct {
    logic srvalid, sel, m0rr, m1rr;
    logic e_m0rv, e_m1rv, e_srr;
  } rvec_t;
  rvec_t rv[8];

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Record AR handshakes on both sides, then advance to the next falling edge.
  task automatic cyc();
    ar_t e;
    if (rst) sb_q.delete();
    else begin
      if (m0ARVALID && m0ARREADY) sb_q.push_back({m0ARADDR, m0ARLEN, {1'b0, m0ARID}});
      if (m1ARVALID && m1ARREADY) sb_q.push_back({m1ARADDR, m1ARLEN, {1'b1, m1ARID}});
      if (sARVALID && sARREADY) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_ar actual=%0h expected=none", sARID);
        end else begin
          e = sb_q.pop_front();
          chk("sb_ar", {sARADDR, sARLEN, sARID}, e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic rbeat(input logic k, input logic last);
    sRVALID = 1'b1; sRID = {k, 4'h0}; sRLAST = last; m0RREADY = 1'b1; m1RREADY = 1'b1;
    #1; cyc();
    sRVALID = 1'b0; sRLAST = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] pat;
    logic exp1;
    rst = 1'b1; sARREADY = 1'b0;
    m0ARVALID = 1'b1; m0ARADDR = '0; m0ARLEN = '0; m0ARID = '0; m0RREADY = 1'b0;
    m1ARVALID = 1'b0; m1ARADDR = '0; m1ARLEN = '0; m1ARID = '0; m1RREADY = 1'b0;
    sRVALID = 1'b0; sRDATA = '0; sRLAST = 1'b0; sRID = '0;

    rv[0] = '{1, 1, 0, 1, 0, 1, 1};
    rv[1] = '{1, 0, 0, 1, 1, 0, 0};
    rv[2] = '{1, 1, 0, 1, 0, 1, 1};
    rv[3] = '{1, 0, 0, 1, 1, 0, 0};
    rv[4] = '{0, 1, 0, 1, 0, 0, 1};
    rv[5] = '{1, 0, 1, 1, 1, 0, 1};
    rv[6] = '{1, 1, 1, 0, 0, 1, 0};
    rv[7] = '{0, 0, 1, 0, 0, 0, 1};

    // Reset cycle: no AR grant even with a request pending.
    #1; chk("rst_m0arready", m0ARREADY, 0);
    cyc();
    #1;
    chk("rst_sarvalid", sARVALID, 0); chk("rst_idle", idle, 1); chk("rst_err", err, 0);
    chk("rst_saraddr", sARADDR, 0); chk("rst_sarid", sARID, 0);
    cyc();

    // Single master: 0x1000 / LEN 3 / ID 2.
    rst = 1'b0; m0ARADDR = 32'h1000; m0ARLEN = 4'd3; m0ARID = 4'd2; sARREADY = 1'b1;
    #1; chk("single_m0arready", m0ARREADY, 1); chk("single_m1arready", m1ARREADY, 0);
    cyc();
    m0ARVALID = 1'b0;
    #1;
    chk("single_sarvalid", sARVALID, 1); chk("single_sarid", sARID, 5'h02);
    chk("single_saraddr", sARADDR, 32'h1000); chk("single_idle_busy", idle, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      pat = {4{32'hA000_0000 + 32'(i)}};
      sRVALID = 1'b1; sRID = 5'h02; sRLAST = (i == 3); sRDATA = pat; m0RREADY = 1'b1;
      #1;
      chk("single_m0rvalid", m0RVALID, 1); chk("single_m1rvalid", m1RVALID, 0);
      chk("single_m0rid", m0RID, 4'd2); chk("single_m0rdata", m0RDATA, pat);
      chk("single_m0rlast", m0RLAST, (i == 3)); chk("single_srready", sRREADY, 1);
      cyc();
    end
    sRVALID = 1'b0; sRLAST = 1'b0;
    #1; chk("single_idle_after", idle, 1); chk("single_err", err, 0);

    // Contention: m0 was granted last, so m1 leads and grants then alternate.
    m0ARVALID = 1'b1; m0ARID = 4'd1; m1ARVALID = 1'b1; m1ARID = 4'd3; m1ARLEN = 4'd0; m0ARLEN = 4'd1;
    for (int i = 0; i < 4; i++) begin
      m0ARADDR = 32'h2000 + 32'(i * 16); m1ARADDR = 32'h3000 + 32'(i * 16);
      exp1 = (i % 2 == 0);
      #1;
      chk("cont_m1arready", m1ARREADY, exp1); chk("cont_m0arready", m0ARREADY, !exp1);
      if (i > 0) chk("cont_sarid_msb", sARID[IDW], !exp1);
      cyc();
    end
    // Both masters now at MAX_OUT.
    #1; chk("full_m0arready", m0ARREADY, 0); chk("full_m1arready", m1ARREADY, 0);
    chk("cont_last_sel", sARID[IDW], 0);
    cyc();

    // Throttle: m1 stays blocked in the RLAST cycle, granted in the next.
    m0ARVALID = 1'b0;
    sRVALID = 1'b1; sRID = {1'b1, 4'h3}; sRLAST = 1'b1; m1RREADY = 1'b1;
    #1;
    chk("thr_sarvalid", sARVALID, 0); chk("thr_blocked", m1ARREADY, 0);
    chk("thr_m1rvalid", m1RVALID, 1);
    cyc();
    sRVALID = 1'b0; sRLAST = 1'b0;
    #1; chk("thr_released", m1ARREADY, 1);
    cyc();
    m1ARVALID = 1'b0;
    #1; chk("thr_sarid", sARID, {1'b1, 4'h3});
    cyc();
    for (int i = 0; i < 4; i++) rbeat(i[0], 1'b1);
    #1; chk("drain_idle", idle, 1); chk("drain_err", err, 0);

    // Backpressure: held request stays stable, no grants, reload on release.
    sARREADY = 1'b0; m0ARVALID = 1'b1; m0ARADDR = 32'h4000; m0ARLEN = 4'd1; m0ARID = 4'd5;
    #1; chk("bp_first_grant", m0ARREADY, 1);
    cyc();
    m1ARVALID = 1'b1; m1ARADDR = 32'h5000; m1ARLEN = 4'd2; m1ARID = 4'd6;
    for (int i = 0; i < 5; i++) begin
      m0ARADDR = 32'h4100 + 32'(i);
      #1;
      chk("bp_m0arready", m0ARREADY, 0); chk("bp_m1arready", m1ARREADY, 0);
      chk("bp_saraddr", sARADDR, 32'h4000); chk("bp_sarlen", sARLEN, 4'd1); chk("bp_sarid", sARID, 5'h05);
      cyc();
    end
    sARREADY = 1'b1;
    #1; chk("bp_release_m1", m1ARREADY, 1); chk("bp_release_m0", m0ARREADY, 0);
    cyc();
    m0ARVALID = 1'b0; m1ARVALID = 1'b0;
    #1; chk("bp_next_sarid", sARID, 5'h16); chk("bp_next_saraddr", sARADDR, 32'h5000);
    cyc();

    // Interleaved R routing, RLAST low so counters are untouched.
    for (int i = 0; i < 8; i++) begin
      pat = {32'(i), 32'hC0DE_0000, 32'(i * 7), 32'h0BAD_F00D};
      sRVALID = rv[i].srvalid; sRID = {rv[i].sel, 4'(i)}; sRLAST = 1'b0; sRDATA = pat;
      m0RREADY = rv[i].m0rr; m1RREADY = rv[i].m1rr;
      #1;
      chk("rv_m0rvalid", m0RVALID, rv[i].e_m0rv); chk("rv_m1rvalid", m1RVALID, rv[i].e_m1rv);
      chk("rv_srready", sRREADY, rv[i].e_srr); chk("rv_m1rdata", m1RDATA, pat);
      chk("rv_m0rid", m0RID, 4'(i));
      cyc();
    end
    sRVALID = 1'b0;

    // Error: extra RLAST to m0 after its count reached zero.
    rbeat(1'b0, 1'b1);
    rbeat(1'b1, 1'b1);
    #1; chk("err_before", err, 0); chk("err_idle_before", idle, 1);
    rbeat(1'b0, 1'b1);
    #1; chk("err_set", err, 1); chk("err_cnt0_zero", idle, 1);
    sARREADY = 1'b0; m0ARVALID = 1'b1; m0ARADDR = 32'h6000; m0ARID = 4'd9;
    #1; chk("err_m0_eligible", m0ARREADY, 1);
    cyc();
    m0ARVALID = 1'b0;
    #1; chk("err_sticky", err, 1); chk("err_sarvalid", sARVALID, 1);
    cyc();

    // Reset with a request held on the shared port.
    rst = 1'b1; m1ARVALID = 1'b1;
    #1; chk("rst2_m1arready", m1ARREADY, 0);
    cyc();
    rst = 1'b0; m1ARVALID = 1'b0;
    #1;
    chk("rst2_sarvalid", sARVALID, 0); chk("rst2_saraddr", sARADDR, 0); chk("rst2_sarlen", sARLEN, 0);
    chk("rst2_sarid", sARID, 0); chk("rst2_err", err, 0); chk("rst2_idle", idle, 1);
    sARREADY = 1'b1; m0ARVALID = 1'b1; m1ARVALID = 1'b1; m0ARID = 4'd4; m1ARID = 4'd7;
    #1; chk("rst2_ptr_m0", m0ARREADY, 1); chk("rst2_ptr_m1", m1ARREADY, 0);
    cyc();
    m0ARVALID = 1'b0; m1ARVALID = 1'b0;
    #1; cyc();
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
